// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the fetch PC and drives a single-outstanding imem port.
// Fetched {pc, inst} pairs are queued in a 2-entry buffer that FI_ID drains.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_next;
    logic [31:0] r_discard_addr;
    logic [31:0] w_discard_addr_next;
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;
    logic        r_head;
    logic        w_head_next;

    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_inst [2];

    logic        w_push;
    logic        w_pop;
    logic        w_tail;
    logic        w_empty;
    logic [1:0]  w_wr_en;
    logic [31:0] w_redirect_target;

    // Word-align the branch target; the low two bits carry no meaning here.
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign w_empty = (r_count == 2'd0);
    assign w_tail  = r_head ^ r_count[0];

    // Memory port: only registered state (and rst) feeds req/addr.
    assign imem_req  = !rst && (((r_state == ST_FETCH) && (r_count != 2'd2)) ||
                                (r_state == ST_DISCARD));
    assign imem_addr = (r_state == ST_DISCARD) ? r_discard_addr : r_fetch_pc;

    assign valid_o = !w_empty;
    assign pc_o    = w_empty ? r_fetch_pc : r_buf_pc[r_head];
    assign inst_o  = w_empty ? 32'h0000_0000 : r_buf_inst[r_head];

    // A redirect suppresses the push of any response arriving in the same cycle.
    assign w_push = (r_state == ST_FETCH) && imem_req && imem_ready && !redirect;
    assign w_pop  = valid_o && !pause;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_push && (w_tail == (gi != 0));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_FETCH;
            r_fetch_pc     <= RESET_PC;
            r_discard_addr <= RESET_PC;
            r_count        <= 2'd0;
            r_head         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_fetch_pc     <= w_fetch_pc_next;
            r_discard_addr <= w_discard_addr_next;
            r_count        <= w_count_next;
            r_head         <= w_head_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]   <= 32'h0000_0000;
                r_buf_inst[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_wr_en[i]) begin
                    r_buf_pc[i]   <= r_fetch_pc;
                    r_buf_inst[i] <= imem_rdata;
                end
            end
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_fetch_pc_next     = r_fetch_pc;
        w_discard_addr_next = r_discard_addr;
        w_count_next        = r_count;
        w_head_next         = r_head;

        if (w_pop) begin
            w_head_next = ~r_head;
        end

        case (r_state)
            ST_FETCH: begin
                // An un-answered request cannot be withdrawn; park on it and drop its data.
                if (redirect && imem_req && !imem_ready) begin
                    w_state_next        = ST_DISCARD;
                    w_discard_addr_next = r_fetch_pc;
                end
            end
            ST_DISCARD: begin
                if (imem_ready) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase

        if (redirect) begin
            w_count_next    = 2'd0;
            w_fetch_pc_next = w_redirect_target;
        end else begin
            if (w_push) begin
                w_fetch_pc_next = r_fetch_pc + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 2'd1;
                2'b01:   w_count_next = r_count - 2'd1;
                default: w_count_next = r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: wait-state memory model, pause, redirect/discard, wrap, async reset.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] XMASK  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    int waits = 0;
    int wcnt  = 0;
    int n_vec = 0;
    int n_err = 0;

    logic [31:0] pop_pc_log   [$];
    logic [31:0] pop_inst_log [$];
    logic [31:0] exp_log [16] = '{
        32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C,
        32'h0000_0010, 32'h0000_0014, 32'h0000_0018, 32'h0000_001C,
        32'h0000_0300, 32'h0000_0304, 32'h0000_000C, 32'h0000_0010,
        32'h0000_0100, 32'h0000_0104, 32'hFFFF_FFF8, 32'hFFFF_FFFC
    };

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .valid_o     (valid_o)
    );

    // Memory: answers after 'waits' idle cycles; data derived from the address.
    assign imem_ready = imem_req && (wcnt >= waits);
    assign imem_rdata = imem_addr ^ XMASK;

    always @(posedge clk) begin
        if (imem_req && !imem_ready) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        if (!rst && valid_o && !pause) begin
            pop_pc_log.push_back(pc_o);
            pop_inst_log.push_back(inst_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pause = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset state
        step(); step(); #2;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(valid_o),  32'd0);
        chk("rst_inst",  inst_o,        32'd0);
        chk("rst_pc",    pc_o,          RST_PC);
        chk("rst_addr",  imem_addr,     RST_PC);

        // Zero-wait stream from RESET_PC
        step(); rst = 1'b0; #2;
        chk("a_req",   32'(imem_req), 32'd1);
        chk("a_addr",  imem_addr,     RST_PC);
        chk("a_valid", 32'(valid_o),  32'd0);
        step(); #2;
        chk("a_valid1", 32'(valid_o), 32'd1);
        chk("a_pc0",    pc_o,         RST_PC);
        chk("a_inst0",  inst_o,       RST_PC ^ XMASK);
        for (int k = 1; k < 5; k++) begin
            step(); #2;
            chk("a_pc",   pc_o,   RST_PC + 32'(4 * k));
            chk("a_inst", inst_o, (RST_PC + 32'(4 * k)) ^ XMASK);
        end

        // Redirect to 0, then pause for 5 cycles, then 2 wait states
        step(); redirect = 1'b1; redirect_pc = 32'h0; #2;
        step(); redirect = 1'b0; pop_pc_log.delete(); pop_inst_log.delete(); #2;
        chk("b_valid", 32'(valid_o), 32'd0);
        chk("b_req",   32'(imem_req), 32'd1);
        chk("b_addr",  imem_addr,    32'h0);
        step(); #2;
        chk("b_pc0",   pc_o,   32'h0);
        chk("b_inst0", inst_o, XMASK);
        step(); #2; chk("b_pc4", pc_o, 32'h4);
        step(); #2; chk("b_pc8", pc_o, 32'h8);
        step(); pause = 1'b1; #2; chk("b_pcC", pc_o, 32'hC);
        step(); waits = 2; #2;
        chk("p_req",   32'(imem_req), 32'd0);
        chk("p_valid", 32'(valid_o),  32'd1);
        chk("p_pc",    pc_o,          32'hC);
        for (int k = 0; k < 3; k++) begin
            step(); #2;
            chk("p_hold_req", 32'(imem_req), 32'd0);
            chk("p_hold_pc",  pc_o,          32'hC);
        end
        step(); pause = 1'b0; #2;
        chk("p_rel_req", 32'(imem_req), 32'd0);
        chk("p_rel_pc",  pc_o,          32'hC);
        step(); #2;
        chk("p_pc10",   pc_o,          32'h10);
        chk("p_inst10", inst_o,        32'h10 ^ XMASK);
        chk("w_req",    32'(imem_req), 32'd1);
        chk("w_addr",   imem_addr,     32'h14);
        for (int k = 0; k < 2; k++) begin
            step(); #2;
            chk("w_gap_valid", 32'(valid_o), 32'd0);
            chk("w_hold_addr", imem_addr,    32'h14);
        end
        for (int k = 0; k < 7; k++) begin
            step(); #2;
            chk("w_valid", 32'(valid_o), (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("w_addr",  imem_addr,    32'h18 + 32'(4 * (k / 3)));
            if (k % 3 == 0) chk("w_pc", pc_o, 32'h14 + 32'(4 * (k / 3)));
        end
        waits = 4;

        // Redirect while a 4-wait access to 0x20 is pending, then a second one in DISCARD
        step(); redirect = 1'b1; redirect_pc = 32'h200; #2;
        chk("c_addr", imem_addr,    32'h20);
        chk("c_req",  32'(imem_req), 32'd1);
        step(); redirect = 1'b0; #2;
        chk("c_disc_addr",  imem_addr,   32'h20);
        chk("c_disc_pc",    pc_o,        32'h200);
        chk("c_disc_valid", 32'(valid_o), 32'd0);
        step(); redirect = 1'b1; redirect_pc = 32'h300; #2;
        chk("c_disc_addr2", imem_addr, 32'h20);
        step(); redirect = 1'b0; #2;
        chk("c_last_addr", imem_addr,    32'h20);
        chk("c_last_req",  32'(imem_req), 32'd1);
        chk("c_last_pc",   pc_o,         32'h300);
        for (int k = 0; k < 5; k++) begin
            step(); #2;
            chk("c_new_addr",  imem_addr,   32'h300);
            chk("c_new_valid", 32'(valid_o), 32'd0);
        end
        step(); #2;
        chk("c_pc300",   pc_o,   32'h300);
        chk("c_inst300", inst_o, 32'h300 ^ XMASK);
        waits = 0;

        // Redirect consuming head 0x10 while 0x14 is buffered; low target bits ignored
        step(); redirect = 1'b1; redirect_pc = 32'hC; #2;
        chk("d_pc304", pc_o, 32'h304);
        step(); redirect = 1'b0; #2;
        chk("d_valid", 32'(valid_o), 32'd0);
        chk("d_addr",  imem_addr,    32'hC);
        step(); #2; chk("d_pcC", pc_o, 32'hC);
        step(); pause = 1'b1; #2; chk("d_pc10", pc_o, 32'h10);
        step(); #2;
        chk("d_full_req", 32'(imem_req), 32'd0);
        chk("d_full_pc",  pc_o,          32'h10);
        step(); pause = 1'b0; redirect = 1'b1; redirect_pc = 32'h103; #2;
        chk("d_slot_pc", pc_o, 32'h10);
        step(); redirect = 1'b0; #2;
        chk("d_tgt_valid", 32'(valid_o), 32'd0);
        chk("d_tgt_addr",  imem_addr,    32'h100);
        step(); #2;
        chk("d_tgt_pc",    pc_o,          32'h100);
        chk("d_tgt_valid", 32'(valid_o),  32'd1);

        // Address wrap at the top of the address space
        step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; #2;
        chk("e_pc104", pc_o, 32'h104);
        step(); redirect = 1'b0; #2;
        chk("e_addr", imem_addr, 32'hFFFF_FFF8);
        step(); #2; chk("e_pcF8", pc_o, 32'hFFFF_FFF8);
        step(); #2;
        chk("e_pcFC",   pc_o,      32'hFFFF_FFFC);
        chk("e_wrap",   imem_addr, 32'h0);
        step(); #2; chk("e_pc0", pc_o, 32'h0);

        chk("log_len", 32'(pop_pc_log.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < pop_pc_log.size()) begin
                chk($sformatf("log_pc%0d", k),   pop_pc_log[k],   exp_log[k]);
                chk($sformatf("log_inst%0d", k), pop_inst_log[k], exp_log[k] ^ XMASK);
            end
        end

        // Asynchronous reset in the middle of a pending access
        step(); pause = 1'b1; waits = 3; #2;
        chk("f_pc4", pc_o, 32'h4);
        step(); #2;
        chk("f_pend_req",  32'(imem_req), 32'd1);
        chk("f_pend_addr", imem_addr,     32'h8);
        chk("f_pend_vld",  32'(valid_o),  32'd1);
        rst = 1'b1; #1;
        chk("f_rst_req",   32'(imem_req), 32'd0);
        chk("f_rst_valid", 32'(valid_o),  32'd0);
        chk("f_rst_inst",  inst_o,        32'd0);
        chk("f_rst_pc",    pc_o,          RST_PC);
        chk("f_rst_addr",  imem_addr,     RST_PC);
        step(); pause = 1'b0; waits = 0;
        step(); rst = 1'b0; #2;
        chk("f_rel_req",   32'(imem_req), 32'd1);
        chk("f_rel_addr",  imem_addr,     RST_PC);
        chk("f_rel_valid", 32'(valid_o),  32'd0);
        step(); #2;
        chk("f_first_pc",   pc_o,   RST_PC);
        chk("f_first_inst", inst_o, RST_PC ^ XMASK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the five-stage pipeline. It sits directly upstream of the FI_ID pipeline register. It owns the fetch PC and drives a single-outstanding request/response instruction-memory port. Fetched {pc, inst} pairs go into a 2-entry buffer, so memory wait states and FI_ID stalls are decoupled. It also handles branch/jump redirects, including discarding a fetch that is still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pause  in  1  FI_ID stall. FI_ID captures pc_o/inst_o on a rising edge where pause=0.
- redirect  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  32  target address; valid when redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; held stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  response strobe; imem_rdata is valid for imem_addr in this cycle. Ignored when imem_req=0.
- imem_rdata  in  32  instruction word.
- pc_o  out  32  PC presented to FI_ID.
- inst_o  out  32  instruction presented to FI_ID; 32'h0 (NOP) when no instruction is valid.
- valid_o  out  1  buffer head is a real instruction.

## Operation
- State: fetch_pc[31:0], buffer of 2 entries {pc, inst}, count[1:0] (0..2), FSM {FETCH, DISCARD}.
- Reset (async, rst=1): fetch_pc=RESET_PC, count=0, state=FETCH.
  - Outputs while in reset: imem_req=0, imem_addr=RESET_PC, valid_o=0, inst_o=0, pc_o=RESET_PC.
- imem_req = !rst && ((state==FETCH && count<2) || state==DISCARD).
- imem_addr = fetch_pc in FETCH; the latched in-flight address in DISCARD.
- Once imem_req rises, it stays high until imem_ready. A request is never withdrawn, even if a redirect arrives.
- Push: in FETCH, imem_req && imem_ready pushes {fetch_pc, imem_rdata} and sets fetch_pc <= fetch_pc+4 (mod 2^32; wraps 32'hFFFF_FFFC -> 0).
- Pop: valid_o && !pause pops the head.
  - Push and pop in the same cycle leave count unchanged.
  - Push is impossible at count=2.
- Head outputs, all combinational from registers:
  - Buffer not empty: pc_o = head pc, inst_o = head inst, valid_o = 1.
  - Buffer empty: pc_o = fetch_pc, inst_o = 0, valid_o = 0.
- Redirect has highest priority. In the redirect cycle:
  - The head, if popped this cycle (delay slot), is consumed normally.
  - All other entries are flushed: count <= 0, and any same-cycle push is suppressed.
  - fetch_pc <= redirect_pc.
  - If imem_req && !imem_ready: state <= DISCARD, in-flight address latched.
  - Otherwise state stays FETCH; a response arriving in that cycle is dropped.
- DISCARD:
  - imem_req held on the old address; no push.
  - On imem_ready: response dropped, state <= FETCH.
  - A further redirect while in DISCARD only overwrites fetch_pc.
- redirect_pc[1:0] is ignored: fetch_pc takes {redirect_pc[31:2], 2'b00}.
- RTL must avoid combinational paths from imem_rdata to imem_req and from pause to imem_addr.

## Timing
- Zero-wait memory (imem_ready tied to imem_req): the first instruction after reset release is valid on valid_o in the cycle after the first request. Steady-state throughput is 1 instruction/cycle with pause=0.
- With N wait cycles per access, throughput is 1/(N+1).
- Redirect to first target instruction on valid_o, zero-wait memory: 2 cycles. Request at target is issued the cycle after redirect; the target is valid the cycle after that.
- Redirect with a fetch in flight: add the remaining wait cycles of the discarded access.
- pause=1 holds the head. The buffer fills to 2, then imem_req drops until a pop.
- Reset asserted mid-access: everything clears immediately; the in-flight response is never pushed. Memory must tolerate req dropping.

## Test plan
- Reset release, zero-wait memory returning inst=addr^32'hA5A5_0000, pause=0 -> pc_o sequence 0,4,8,... one per cycle; first valid_o=1 one cycle after the first imem_req.
- Memory with 2 wait states -> imem_addr stable across waits; valid_o pulses every 3rd cycle; no duplicated or skipped PCs.
- pause=1 for 5 cycles mid-stream -> count saturates at 2, imem_req=0; after release the held pc/inst pairs come out in order, no loss.
- redirect to 32'h0000_0100 while head pc=0x10 is popped and 0x14 is buffered -> 0x10 consumed; 0x14 never appears; next valid pc_o=0x100 two cycles later.
- redirect to 0x200 while a 3-wait-state access to 0x20 is pending -> imem_addr stays 0x20 until ready; that data is dropped; next request is 0x200. A second redirect to 0x300 during DISCARD -> next request is 0x300.
- rst asserted asynchronously mid-access, RESET_PC=32'hBFC0_0000 -> outputs immediately imem_req=0, valid_o=0, inst_o=0, pc_o=0xBFC0_0000; first request after release is 0xBFC0_0000.
